// File: rtl/systolic_2x2_feeder.sv
// systolic_2x2_feeder: takes one 2x2 operand pair and streams the skewed beats plus a flush beat into systolic_2x2.
// Optional FEEDER_BACK2BACK_EN: accept the next pair during the flush beat's gap and chain it without an idle cycle.
`timescale 1ns/1ps
module systolic_2x2_feeder #(
    parameter int DATA_W     = 32,
    parameter int LOAD_W     = 2,
    parameter int GAP_CYCLES = 30
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] a00,
    input  logic [DATA_W-1:0] a01,
    input  logic [DATA_W-1:0] a10,
    input  logic [DATA_W-1:0] a11,
    input  logic [DATA_W-1:0] b00,
    input  logic [DATA_W-1:0] b01,
    input  logic [DATA_W-1:0] b10,
    input  logic [DATA_W-1:0] b11,
    output logic [DATA_W-1:0] mat1_row0,
    output logic [DATA_W-1:0] mat1_row1,
    output logic [DATA_W-1:0] mat2_col0,
    output logic [DATA_W-1:0] mat2_col1,
    output logic              load_in,
    output logic              busy,
    output logic [1:0]        beat_idx,
    output logic              done
);
    // state | meaning
    // IDLE  | waiting for an operand pair, in_ready high
    // LOAD  | load_in high, beat data on the buses
    // GAP   | load_in low, beat data held
    // FIN   | one-cycle done pulse, buses cleared
    typedef enum logic [1:0] {IDLE, LOAD, GAP, FIN} state_t;

    localparam int CNT_MAX = (LOAD_W > GAP_CYCLES) ? LOAD_W : GAP_CYCLES;
    localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
    localparam logic [CNT_W-1:0] LOAD_LAST = CNT_W'(LOAD_W - 1);
    localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP_CYCLES - 1);
    localparam int OP_W = 4 * DATA_W;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [OP_W-1:0]  op_a;
    logic [OP_W-1:0]  op_b;
    logic [OP_W-1:0]  in_a;
    logic [OP_W-1:0]  in_b;

`ifdef FEEDER_BACK2BACK_EN
    logic [OP_W-1:0]  sh_a;
    logic [OP_W-1:0]  sh_b;
    logic             sh_valid;
`endif

    assign in_a = {a11, a10, a01, a00};
    assign in_b = {b11, b10, b01, b00};

    // Returns {row0, row1, col0, col1} for a beat; operands packed {x11, x10, x01, x00}.
    function automatic logic [OP_W-1:0] beat_word(input logic [1:0]      idx,
                                                   input logic [OP_W-1:0] a,
                                                   input logic [OP_W-1:0] b);
        logic [DATA_W-1:0] z;
        z = '0;
        case (idx)
            2'd0:    beat_word = {a[0 +: DATA_W], z, b[0 +: DATA_W], z};
            2'd1:    beat_word = {a[DATA_W +: DATA_W], a[2*DATA_W +: DATA_W],
                                  b[2*DATA_W +: DATA_W], b[DATA_W +: DATA_W]};
            2'd2:    beat_word = {z, a[3*DATA_W +: DATA_W], z, b[3*DATA_W +: DATA_W]};
            default: beat_word = '0;
        endcase
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            op_a      <= '0;
            op_b      <= '0;
            mat1_row0 <= '0;
            mat1_row1 <= '0;
            mat2_col0 <= '0;
            mat2_col1 <= '0;
            load_in   <= 1'b0;
            busy      <= 1'b0;
            beat_idx  <= 2'd0;
            done      <= 1'b0;
            in_ready  <= 1'b1;
`ifdef FEEDER_BACK2BACK_EN
            sh_a      <= '0;
            sh_b      <= '0;
            sh_valid  <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (in_valid && in_ready) begin
                        op_a     <= in_a;
                        op_b     <= in_b;
                        {mat1_row0, mat1_row1, mat2_col0, mat2_col1} <= beat_word(2'd0, in_a, in_b);
                        load_in  <= 1'b1;
                        busy     <= 1'b1;
                        beat_idx <= 2'd0;
                        cnt      <= LOAD_LAST;
                        in_ready <= 1'b0;
                        state    <= LOAD;
                    end
                end
                LOAD: begin
                    if (cnt == '0) begin
                        load_in <= 1'b0;
                        cnt     <= GAP_LAST;
                        state   <= GAP;
`ifdef FEEDER_BACK2BACK_EN
                        if (beat_idx == 2'd3) in_ready <= 1'b1;
`endif
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                GAP: begin
`ifdef FEEDER_BACK2BACK_EN
                    // Flush beat data is all zeros, so the shadow never disturbs the buses.
                    if (in_valid && in_ready) begin
                        sh_a     <= in_a;
                        sh_b     <= in_b;
                        sh_valid <= 1'b1;
                        in_ready <= 1'b0;
                    end
`endif
                    if (cnt == '0) begin
                        if (beat_idx != 2'd3) begin
                            beat_idx <= beat_idx + 2'd1;
                            {mat1_row0, mat1_row1, mat2_col0, mat2_col1} <=
                                beat_word(beat_idx + 2'd1, op_a, op_b);
                            load_in  <= 1'b1;
                            cnt      <= LOAD_LAST;
                            state    <= LOAD;
                        end else begin
                            {mat1_row0, mat1_row1, mat2_col0, mat2_col1} <= '0;
                            done     <= 1'b1;
                            in_ready <= 1'b0;
                            state    <= FIN;
                        end
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                FIN: begin
`ifdef FEEDER_BACK2BACK_EN
                    if (sh_valid) begin
                        op_a     <= sh_a;
                        op_b     <= sh_b;
                        sh_valid <= 1'b0;
                        {mat1_row0, mat1_row1, mat2_col0, mat2_col1} <= beat_word(2'd0, sh_a, sh_b);
                        load_in  <= 1'b1;
                        beat_idx <= 2'd0;
                        cnt      <= LOAD_LAST;
                        state    <= LOAD;
                    end else begin
                        busy     <= 1'b0;
                        beat_idx <= 2'd0;
                        in_ready <= 1'b1;
                        state    <= IDLE;
                    end
`else
                    busy     <= 1'b0;
                    beat_idx <= 2'd0;
                    in_ready <= 1'b1;
                    state    <= IDLE;
`endif
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_systolic_2x2_feeder.sv
// Randomized self-checking bench for systolic_2x2_feeder: default timing instance plus a LOAD_W=1/GAP_CYCLES=1 instance.
`timescale 1ns/1ps
module tb_systolic_2x2_feeder;
    localparam int W = 32;
`ifdef FEEDER_BACK2BACK_EN
    localparam bit B2B = 1'b1;
`else
    localparam bit B2B = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;
    logic in_valid0, in_valid1;
    logic [W-1:0] ma[2][2], mb[2][2], nxa[2][2], nxb[2][2];
    logic [W-1:0] ea[2][2], eb[2][2], res[2][2];
    logic [W-1:0] a00, a01, a10, a11, b00, b01, b10, b11;

    logic         d0_ready, d0_load, d0_busy, d0_done;
    logic [1:0]   d0_beat;
    logic [W-1:0] d0_row0, d0_row1, d0_col0, d0_col1;
    logic         d1_ready, d1_load, d1_busy, d1_done;
    logic [1:0]   d1_beat;
    logic [W-1:0] d1_row0, d1_row1, d1_col0, d1_col1;

    int sel;
    logic         obs_ready, obs_load, obs_busy, obs_done;
    logic [1:0]   obs_beat;
    logic [W-1:0] obs_row0, obs_row1, obs_col0, obs_col1;

    int n_chk = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    assign a00 = ma[0][0]; assign a01 = ma[0][1]; assign a10 = ma[1][0]; assign a11 = ma[1][1];
    assign b00 = mb[0][0]; assign b01 = mb[0][1]; assign b10 = mb[1][0]; assign b11 = mb[1][1];

    systolic_2x2_feeder #(.DATA_W(W), .LOAD_W(2), .GAP_CYCLES(30)) u_dut0 (
        .clk(clk), .rst(rst), .in_valid(in_valid0), .in_ready(d0_ready),
        .a00(a00), .a01(a01), .a10(a10), .a11(a11),
        .b00(b00), .b01(b01), .b10(b10), .b11(b11),
        .mat1_row0(d0_row0), .mat1_row1(d0_row1), .mat2_col0(d0_col0), .mat2_col1(d0_col1),
        .load_in(d0_load), .busy(d0_busy), .beat_idx(d0_beat), .done(d0_done));

    systolic_2x2_feeder #(.DATA_W(W), .LOAD_W(1), .GAP_CYCLES(1)) u_dut1 (
        .clk(clk), .rst(rst), .in_valid(in_valid1), .in_ready(d1_ready),
        .a00(a00), .a01(a01), .a10(a10), .a11(a11),
        .b00(b00), .b01(b01), .b10(b10), .b11(b11),
        .mat1_row0(d1_row0), .mat1_row1(d1_row1), .mat2_col0(d1_col0), .mat2_col1(d1_col1),
        .load_in(d1_load), .busy(d1_busy), .beat_idx(d1_beat), .done(d1_done));

    always_comb begin
        obs_ready = d0_ready; obs_load = d0_load; obs_busy = d0_busy; obs_done = d0_done;
        obs_beat  = d0_beat;  obs_row0 = d0_row0; obs_row1 = d0_row1;
        obs_col0  = d0_col0;  obs_col1 = d0_col1;
        if (sel == 1) begin
            obs_ready = d1_ready; obs_load = d1_load; obs_busy = d1_busy; obs_done = d1_done;
            obs_beat  = d1_beat;  obs_row0 = d1_row0; obs_row1 = d1_row1;
            obs_col0  = d1_col0;  obs_col1 = d1_col1;
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s obs=%0h exp=%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic set_valid(input int s, input logic v);
        if (s == 0) in_valid0 = v;
        else        in_valid1 = v;
    endtask

    task automatic rand_ops();
        for (int i = 0; i < 2; i++)
            for (int j = 0; j < 2; j++) begin
                ma[i][j] = $urandom;
                mb[i][j] = $urandom;
            end
    endtask

    // Skew rule: row i at beat t carries A[i][t-i], column j carries B[t-j][j], else zero.
    function automatic logic [W-1:0] exp_row(input int i, input int t);
        return (t - i >= 0 && t - i <= 1) ? ea[i][t-i] : '0;
    endfunction

    function automatic logic [W-1:0] exp_col(input int j, input int t);
        return (t - j >= 0 && t - j <= 1) ? eb[t-j][j] : '0;
    endfunction

    task automatic chk_idle(input string tag);
        chk({tag, "_load"}, obs_load, 0);
        chk({tag, "_busy"}, obs_busy, 0);
        chk({tag, "_done"}, obs_done, 0);
        chk({tag, "_beat"}, obs_beat, 0);
        chk({tag, "_ready"}, obs_ready, 1);
        chk({tag, "_data"}, {obs_row0, obs_row1, obs_col0, obs_col1}, 0);
    endtask

    // pre: pair already accepted (back-to-back chain); abort_t: cycle at which rst hits.
    task automatic run_seq(input int s, input bit pre, input bit hold, input bit b2b_next, input int abort_t);
        int lw, gw, per, tot, beat, ph;
        bit got;
        logic [W-1:0] rows[4][2], cols[4][2];
        logic [W-1:0] acc, prod;
        lw = (s == 0) ? 2 : 1;
        gw = (s == 0) ? 30 : 1;
        per = lw + gw;
        tot = 4 * per;
        sel = s;
        for (int i = 0; i < 2; i++)
            for (int j = 0; j < 2; j++) begin
                ea[i][j] = ma[i][j];
                eb[i][j] = mb[i][j];
            end
        for (int t = 0; t < 4; t++) begin
            rows[t][0] = '0; rows[t][1] = '0; cols[t][0] = '0; cols[t][1] = '0;
        end
        if (!pre) begin
            @(negedge clk);
            set_valid(s, 1'b1);
            got = 1'b0;
            for (int i = 0; i < 300; i++) begin
                if (obs_ready) begin got = 1'b1; break; end
                @(negedge clk);
            end
            chk("accept", got, 1);
            if (!got) begin set_valid(s, 1'b0); return; end
            @(posedge clk);
        end
        for (int t = 1; t <= tot + 1; t++) begin
            @(negedge clk);
            if (t == 1 && !hold && !pre) set_valid(s, 1'b0);
            if (t == 1 && hold) rand_ops();
            if (hold && t == 3 * per + 1) set_valid(s, 1'b0);
            if (t == abort_t) begin
                set_valid(s, 1'b0);
                rst = 1'b1;
                #1;
                chk_idle("abort");
                repeat (3) begin
                    @(negedge clk);
                    chk("abort_done", obs_done, 0);
                end
                rst = 1'b0;
                return;
            end
            if (t <= tot) begin
                beat = (t - 1) / per;
                ph   = (t - 1) % per;
                chk("load", obs_load, (ph < lw));
                chk("busy", obs_busy, 1);
                chk("done_early", obs_done, 0);
                chk("beat_idx", obs_beat, beat);
                chk("ready", obs_ready, (B2B && beat == 3 && ph >= lw));
                chk("row0", obs_row0, exp_row(0, beat));
                chk("row1", obs_row1, exp_row(1, beat));
                chk("col0", obs_col0, exp_col(0, beat));
                chk("col1", obs_col1, exp_col(1, beat));
                if (ph == 0) begin
                    rows[beat][0] = obs_row0; rows[beat][1] = obs_row1;
                    cols[beat][0] = obs_col0; cols[beat][1] = obs_col1;
                end
            end else begin
                chk("fin_done", obs_done, 1);
                chk("fin_busy", obs_busy, 1);
                chk("fin_load", obs_load, 0);
                chk("fin_ready", obs_ready, 0);
                chk("fin_data", {obs_row0, obs_row1, obs_col0, obs_col1}, 0);
            end
            if (b2b_next && t == tot) begin
                ma = nxa;
                mb = nxb;
                set_valid(s, 1'b1);
            end
            if (b2b_next && t == tot + 1) set_valid(s, 1'b0);
        end
        if (!b2b_next) begin
            @(negedge clk);
            chk("post_ready", obs_ready, 1);
            chk("post_busy", obs_busy, 0);
            chk("post_done", obs_done, 0);
            chk("post_load", obs_load, 0);
        end
        // Output-stationary 2x2 array fed by the captured beats vs. plain matrix product.
        for (int i = 0; i < 2; i++)
            for (int j = 0; j < 2; j++) begin
                acc = '0;
                for (int t = 0; t < 4; t++)
                    if (t - i >= 0 && t - j >= 0) acc = acc + rows[t-j][i] * cols[t-i][j];
                prod = ea[i][0] * eb[0][j] + ea[i][1] * eb[1][j];
                chk("array", acc, prod);
                res[i][j] = acc;
            end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog obs=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1;
        in_valid0 = 1'b0;
        in_valid1 = 1'b0;
        sel = 0;
        for (int i = 0; i < 2; i++)
            for (int j = 0; j < 2; j++) begin
                ma[i][j] = '0; mb[i][j] = '0; nxa[i][j] = '0; nxb[i][j] = '0; res[i][j] = '0;
            end
        repeat (2) @(negedge clk);
        sel = 0; #1; chk_idle("rst0");
        sel = 1; #1; chk_idle("rst1");
        rst = 1'b0;
        sel = 0;
        repeat (50) begin
            @(negedge clk);
            chk("idle_load", obs_load, 0);
            chk("idle_ready", obs_ready, 1);
        end

        ma[0][0] = 4; ma[0][1] = 2; ma[1][0] = 1; ma[1][1] = 8;
        mb[0][0] = 8; mb[0][1] = 1; mb[1][0] = 2; mb[1][1] = 4;
        run_seq(0, 1'b0, 1'b0, 1'b0, 0);
        chk("res00", res[0][0], 32'h24);
        chk("res01", res[0][1], 32'h0C);
        chk("res10", res[1][0], 32'h18);
        chk("res11", res[1][1], 32'h21);

        rand_ops();
        run_seq(0, 1'b0, 1'b1, 1'b0, 0);
        rand_ops();
        run_seq(0, 1'b0, 1'b0, 1'b0, 0);

        rand_ops();
        run_seq(0, 1'b0, 1'b0, 1'b0, 32 + 2 + 3);
        sel = 0; #1; chk_idle("after_abort");
        rand_ops();
        run_seq(0, 1'b0, 1'b0, 1'b0, 0);

        repeat (3) begin
            rand_ops();
            run_seq(1, 1'b0, 1'b0, 1'b0, 0);
        end

`ifdef FEEDER_BACK2BACK_EN
        rand_ops();
        for (int i = 0; i < 2; i++)
            for (int j = 0; j < 2; j++) begin
                nxa[i][j] = $urandom;
                nxb[i][j] = $urandom;
            end
        run_seq(0, 1'b0, 1'b0, 1'b1, 0);
        run_seq(0, 1'b1, 1'b0, 1'b0, 0);
        rand_ops();
        run_seq(1, 1'b0, 1'b0, 1'b1, 0);
        run_seq(1, 1'b1, 1'b0, 1'b0, 0);
`endif

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
